reg_arb: RTL and testbench
==========================

REG_ARB -- requirements
Module: reg_arb

Interface
REQ-001 Parameter N, default 4: number of requesters.
REQ-002 Parameter W, default 8: data width of the shared register.
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive writes by one locked requester.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 req  input  N  per-requester write request, level-held until served or withdrawn.
REQ-007 lock  input  N  per-requester request to keep the grant for back-to-back writes.
REQ-008 d_in  input  N*W  packed write data; requester i occupies bits [i*W +: W].
REQ-009 gnt  output  N  registered one-hot (or zero) grant.
REQ-010 ack  output  N  one-cycle pulse; write by requester i committed.
REQ-011 q  output  W  contents of the shared register.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States SHALL be IDLE, GRANT and LOCK; gnt SHALL be zero only in IDLE.
REQ-014 Arbitration SHALL be round-robin: search req starting at index ptr, ascending, wrapping at N.
REQ-015 IDLE, any req high at edge: gnt <= one-hot of winner, state <= GRANT; no write on this edge.
REQ-016 GRANT/LOCK, gnt[i]=1 and req[i]=1 at edge: q <= d_in[i] and ack[i] <= 1 on the same edge (ack visible in the cycle q shows new data).
REQ-017 ack SHALL be high for exactly one cycle per committed write; at most one ack bit high.
REQ-018 After a write by i with lock[i]=1 and hold_cnt < MAX_HOLD-1: gnt unchanged, state <= LOCK, hold_cnt <= hold_cnt+1.
REQ-019 After a write by i otherwise (lock low or hold_cnt = MAX_HOLD-1): ptr <= (i+1) mod N, hold_cnt <= 0, rearbitrate on the same edge from (i+1) mod N over current req; requester i is eligible only if no other requester is high.
REQ-020 Rearbitration finding no req: gnt <= 0, state <= IDLE.
REQ-021 gnt[i]=1 with req[i]=0 at edge (withdrawn): no write, no ack, ptr <= (i+1) mod N, hold_cnt <= 0, rearbitrate as REQ-019.
REQ-022 lock on a non-granted requester SHALL be ignored.
REQ-023 Back-to-back grants SHALL incur no idle cycle: one write per cycle while any req is high after the first grant.
REQ-024 hold_cnt SHALL be wide enough for MAX_HOLD-1; MAX_HOLD=1 SHALL disable locking.
REQ-025 q SHALL change only on a committed write.

Reset
REQ-026 rst low SHALL immediately force gnt=0, ack=0, q=0, busy=0, ptr=0, hold_cnt=0, state=IDLE, independent of clk.
REQ-027 Reset asserted mid-write or mid-lock SHALL abort without ack; first grant after release SHALL search from index 0.
REQ-028 Reset deassertion SHALL take effect at the first rising edge after rst goes high.

Structure
REQ-029 Package reg_arb_pkg SHALL hold the state encoding and the default N, W, MAX_HOLD constants.
REQ-030 The shared register SHALL be a sub-module reg_arn (W-bit, enable, async active-low reset to 0); the arbiter drives its en and d.
REQ-031 Round-robin select SHALL be a function in the arbiter, not a separate module.

Verification
REQ-032 Reset: rst=0 with random req/d_in -> gnt=0, ack=0, q=0, busy=0 asynchronously.
REQ-033 Single: req=0001, d_in[0]=31 -> gnt=0001 after 1 edge, q=31 and ack=0001 after 2nd edge, gnt=0000 after 2nd edge if req dropped.
REQ-034 Fairness: req=1111 held, d_in[i]=10+i -> q sequence 10,11,12,13,10 on consecutive edges; ack rotates 0001,0010,0100,1000.
REQ-035 Lock cap: req=0011, lock=0001, MAX_HOLD=4, d_in[0]=127, d_in[1]=12 -> four writes of 127, then 12; gnt moves to 0010 after fourth ack.
REQ-036 Withdraw: grant on 0010, then req[1] dropped before write -> no ack, q unchanged, gnt moves to next high requester.
REQ-037 Reset mid-lock: rst low during LOCK -> q=0, no ack; after release, req=1010 -> first gnt=0010.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and default sizing for the register arbiter.
package reg_arb_pkg;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_W        = 8;
  localparam int unsigned DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_arn.sv
// W-bit shared storage register with load enable, cleared by reset.
module reg_arn #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable; reset clears contents immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_arb.sv
// Round-robin arbiter granting N requesters write access to one shared register,
// with an optional bounded lock for back-to-back writes by the same requester.
module reg_arb
  import reg_arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned W        = DEF_W,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] d_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  // First high request at or after start, wrapping; MSB flags "found".
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] start);
    logic [IW:0]   res;
    logic [IW-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(start) + k) % N);
      if (!res[IW] && r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  state_t        state, state_n;
  logic [N-1:0]  gnt_n, ack_n;
  logic [IW-1:0] gidx, gidx_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [IW-1:0] nxt;
  logic [IW:0]   pick;
  logic          do_rearb;
  logic          wr_en;
  logic [W-1:0]  wr_d;

  // Next-state, grant, write and pointer decisions.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    gidx_n   = gidx;
    ptr_n    = ptr;
    hold_n   = hold_cnt;
    ack_n    = '0;
    wr_en    = 1'b0;
    do_rearb = 1'b0;
    pick     = '0;
    wr_d     = '0;
    nxt      = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);

    for (int unsigned i = 0; i < N; i++) begin
      if (gidx == IW'(i)) begin
        wr_d = d_in[i*W +: W];
      end
    end

    case (state)
      ST_IDLE: begin
        pick = rr_pick(req, ptr);
        if (pick[IW]) begin
          gnt_n   = onehot(pick[IW-1:0]);
          gidx_n  = pick[IW-1:0];
          state_n = ST_GRANT;
        end
      end
      ST_GRANT, ST_LOCK: begin
        if (req[gidx]) begin
          wr_en       = 1'b1;
          ack_n[gidx] = 1'b1;
          if (lock[gidx] && (hold_cnt < HOLD_LAST)) begin
            hold_n  = hold_cnt + HW'(1);
            state_n = ST_LOCK;
          end else begin
            do_rearb = 1'b1;
          end
        end else begin
          // Withdrawn request: give up the grant without writing.
          do_rearb = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase

    // Hand off starting just after the current owner; owner itself comes last.
    if (do_rearb) begin
      ptr_n  = nxt;
      hold_n = '0;
      pick   = rr_pick(req, nxt);
      if (pick[IW]) begin
        gnt_n   = onehot(pick[IW-1:0]);
        gidx_n  = pick[IW-1:0];
        state_n = ST_GRANT;
      end else begin
        gnt_n   = '0;
        state_n = ST_IDLE;
      end
    end
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      ack      <= '0;
      gidx     <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      ack      <= ack_n;
      gidx     <= gidx_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  assign busy = (state != ST_IDLE);

  reg_arn #(.W(W)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (wr_en),
    .d   (wr_d),
    .q   (q)
  );

endmodule

// File: tb/tb_reg_arb.sv
// Scoreboard bench for reg_arb: directed stimulus queues expected writes, a
// negedge monitor checks every ack pulse against the queue.
module tb_reg_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] d_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic           busy;

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  reg_arb #(.N(N), .W(W), .MAX_HOLD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .lock (lock),
    .d_in (d_in),
    .gnt  (gnt),
    .ack  (ack),
    .q    (q),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [N-1:0] a, input logic [W-1:0] v);
    exp_t e;
    e.ack = a;
    e.q   = v;
    sb.push_back(e);
  endtask

  // Monitor: every ack pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (rst && (ack != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack", 32'(ack), 32'(e.ack));
        chk("sb_q", 32'(q), 32'(e.q));
      end
    end
  end

  initial begin
    // Reset with random inputs
    rst  = 1'b0;
    req  = 4'($urandom);
    lock = 4'($urandom);
    d_in = 32'($urandom);
    #12;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    req  = '0;
    lock = '0;
    d_in = '0;
    rst  = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'(0));

    // Single requester
    req = 4'b0001;
    d_in[0*W +: W] = 8'd31;
    step();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_busy", 32'(busy), 32'(1));
    chk("single_q_before", 32'(q), 32'(0));
    expect_wr(4'b0001, 8'd31);
    step();
    chk("single_q", 32'(q), 32'd31);
    chk("single_regrant", 32'(gnt), 32'h1);
    req = '0;
    step();
    chk("single_release_gnt", 32'(gnt), 32'(0));
    chk("single_release_busy", 32'(busy), 32'(0));
    chk("single_hold_q", 32'(q), 32'd31);

    // Async reset pulse mid-cycle returns pointer to 0
    #2;
    rst = 1'b0;
    #1;
    chk("pulse_q", 32'(q), 32'(0));
    rst = 1'b1;
    step();

    // Fairness: all requesting
    req = 4'b1111;
    for (int i = 0; i < 4; i++) d_in[i*W +: W] = 8'(10 + i);
    step();
    chk("fair_first_gnt", 32'(gnt), 32'h1);
    expect_wr(4'b0001, 8'd10);
    expect_wr(4'b0010, 8'd11);
    expect_wr(4'b0100, 8'd12);
    expect_wr(4'b1000, 8'd13);
    expect_wr(4'b0001, 8'd10);
    begin
      logic [W-1:0] fq[5];
      logic [N-1:0] fg[5];
      fq = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd10};
      fg = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      for (int i = 0; i < 5; i++) begin
        step();
        chk("fair_q", 32'(q), 32'(fq[i]));
        chk("fair_gnt", 32'(gnt), 32'(fg[i]));
      end
    end
    req = '0;
    step();
    chk("fair_idle", 32'(gnt), 32'(0));

    // Lock cap (pointer now at 2, search 2,3,0 picks requester 0)
    req  = 4'b0011;
    lock = 4'b0001;
    d_in[0*W +: W] = 8'd127;
    d_in[1*W +: W] = 8'd12;
    step();
    chk("lock_first_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 4; i++) expect_wr(4'b0001, 8'd127);
    expect_wr(4'b0010, 8'd12);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_hold_gnt", 32'(gnt), 32'h1);
      chk("lock_q", 32'(q), 32'd127);
    end
    step();
    chk("lock_cap_gnt", 32'(gnt), 32'h2);
    req = 4'b0010;
    step();
    chk("lock_next_q", 32'(q), 32'd12);
    req = '0;
    step();
    chk("lock_idle", 32'(gnt), 32'(0));

    // Withdraw before write (pointer at 2 -> sole requester 1)
    req = 4'b0010;
    d_in[3*W +: W] = 8'd99;
    step();
    chk("wd_gnt", 32'(gnt), 32'h2);
    req = 4'b1000;
    step();
    chk("wd_q_unchanged", 32'(q), 32'd12);
    chk("wd_moved_gnt", 32'(gnt), 32'h8);
    expect_wr(4'b1000, 8'd99);
    step();
    chk("wd_q_new", 32'(q), 32'd99);
    req = '0;
    step();
    chk("wd_idle", 32'(gnt), 32'(0));

    // Reset during LOCK
    req  = 4'b0001;
    lock = 4'b0001;
    d_in[0*W +: W] = 8'd55;
    step();
    expect_wr(4'b0001, 8'd55);
    step();
    chk("rl_locked_gnt", 32'(gnt), 32'h1);
    chk("rl_q", 32'(q), 32'd55);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rl_rst_q", 32'(q), 32'(0));
    chk("rl_rst_ack", 32'(ack), 32'(0));
    chk("rl_rst_gnt", 32'(gnt), 32'(0));
    chk("rl_rst_busy", 32'(busy), 32'(0));
    req = 4'b1010;
    step();
    chk("rl_held_gnt", 32'(gnt), 32'(0));
    chk("rl_held_q", 32'(q), 32'(0));
    rst = 1'b1;
    step();
    chk("rl_first_gnt", 32'(gnt), 32'h2);
    expect_wr(4'b0010, 8'd12);
    step();
    chk("rl_q_after", 32'(q), 32'd12);
    chk("rl_rotate_gnt", 32'(gnt), 32'h8);
    req = '0;
    step();
    chk("rl_idle", 32'(gnt), 32'(0));
    step();

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
